cache_nway: RTL and testbench

//  - Parametrised N-way set-associative, write-back, write-allocate cache.
//  - Includes its own tag/valid/dirty/data arrays, tree pseudo-LRU and control FSM.
//  - Succeeds the fixed 2-way datapath-only cache and needs no external controller.
//  - Sits between a CPU-side 256-bit line port (I/D arbiter or L1) and physical

---
 rtl/cache_nway.sv | 216 +++++++++++++++++++++
 tb/tb_cache_nway.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway.sv
// N-way set-associative, write-back, write-allocate cache with tree pseudo-LRU replacement.
// CPU side takes 256-bit line requests; memory side moves whole lines.
module cache_nway #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_index  = 3,
    parameter int unsigned num_ways = 4,
    parameter int unsigned s_tag    = 32 - s_offset - s_index
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata,
    input  logic [31:0]  mem_byte_enable256,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int unsigned NumSets  = 2 ** s_index;
    localparam int unsigned WayBits  = $clog2(num_ways);
    localparam int unsigned PlruBits = num_ways - 1;
    localparam int unsigned NodeBits = (PlruBits > 1) ? $clog2(PlruBits) : 1;

    typedef enum logic [1:0] {StIdle, StCheck, StWriteback, StFill} state_e;

    state_e                                r_state;
    logic [s_index-1:0]                    r_set;
    logic [s_tag-1:0]                      r_tag;
    logic                                  r_write;
    logic [WayBits-1:0]                    r_victim;
    logic                                  r_pmem_read;
    logic                                  r_pmem_write;
    logic [31:0]                           r_pmem_address;
    logic [255:0]                          r_pmem_wdata;

    logic [255:0]                          r_data    [NumSets][num_ways];
    logic [s_tag-1:0]                      r_tag_arr [NumSets][num_ways];
    logic [NumSets-1:0][num_ways-1:0]      r_valid;
    logic [NumSets-1:0][num_ways-1:0]      r_dirty;
    logic [NumSets-1:0][PlruBits-1:0]      r_plru;

    logic [num_ways-1:0]                   w_valid_set;
    logic [num_ways-1:0]                   w_dirty_set;
    logic [PlruBits-1:0]                   w_plru_set;
    logic [PlruBits-1:0]                   w_plru_next;
    logic [num_ways-1:0]                   w_match;
    logic [num_ways-1:0]                   w_path_ok;
    logic                                  w_hit;
    logic [WayBits-1:0]                    w_hit_way;
    logic [WayBits-1:0]                    w_plru_way;
    logic [WayBits-1:0]                    w_inv_way;
    logic                                  w_any_inv;
    logic [WayBits-1:0]                    w_victim;
    logic                                  w_victim_dirty;
    logic [255:0]                          w_hit_line;
    logic [255:0]                          w_merged;
    logic [s_tag-1:0]                      w_req_tag;
    logic [s_index-1:0]                    w_req_set;
    logic                                  w_unused_offset;

    assign w_req_tag       = mem_address[31 -: s_tag];
    assign w_req_set       = mem_address[s_offset +: s_index];
    assign w_unused_offset = ^mem_address[s_offset-1:0];

    assign w_valid_set = r_valid[r_set];
    assign w_dirty_set = r_dirty[r_set];
    assign w_plru_set  = r_plru[r_set];

    for (genvar w = 0; w < num_ways; w++) begin : g_match
        assign w_match[w] = w_valid_set[w] && (r_tag_arr[r_set][w] == r_tag);
    end

    assign w_hit      = |w_match;
    assign w_hit_line = r_data[r_set][w_hit_way];

    always_comb begin
        w_hit_way = '0;
        for (int w = 0; w < num_ways; w++) begin
            if (w_match[WayBits'(w)]) w_hit_way = WayBits'(w);
        end
    end

    // A way is the PLRU victim when every node on its root-to-leaf path points towards it.
    always_comb begin
        w_path_ok = '1;
        for (int w = 0; w < num_ways; w++) begin
            for (int l = 0; l < WayBits; l++) begin
                if (w_plru_set[NodeBits'((1 << l) - 1 + (w >> (WayBits - l)))] !=
                    1'(w >> (WayBits - 1 - l))) begin
                    w_path_ok[WayBits'(w)] = 1'b0;
                end
            end
        end
        w_plru_way = '0;
        for (int w = 0; w < num_ways; w++) begin
            if (w_path_ok[WayBits'(w)]) w_plru_way = WayBits'(w);
        end
    end

    // Each node on the hit way's path is flipped to point away from it.
    always_comb begin
        w_plru_next = w_plru_set;
        for (int l = 0; l < WayBits; l++) begin
            w_plru_next[NodeBits'((1 << l) - 1 + (int'(w_hit_way) >> (WayBits - l)))] =
                ~1'(int'(w_hit_way) >> (WayBits - 1 - l));
        end
    end

    always_comb begin
        w_inv_way = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!w_valid_set[WayBits'(w)]) w_inv_way = WayBits'(w);
        end
    end

    assign w_any_inv      = ~&w_valid_set;
    assign w_victim       = w_any_inv ? w_inv_way : w_plru_way;
    assign w_victim_dirty = w_valid_set[w_victim] && w_dirty_set[w_victim];

    for (genvar b = 0; b < 32; b++) begin : g_merge
        assign w_merged[8*b +: 8] = mem_byte_enable256[b] ? mem_wdata[8*b +: 8]
                                                          : w_hit_line[8*b +: 8];
    end

    assign mem_resp     = (r_state == StCheck) && w_hit;
    assign mem_rdata    = mem_resp ? w_hit_line : '0;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_set          <= '0;
            r_tag          <= '0;
            r_write        <= 1'b0;
            r_victim       <= '0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_valid        <= '0;
            r_dirty        <= '0;
            r_plru         <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (mem_read || mem_write) begin
                        r_set   <= w_req_set;
                        r_tag   <= w_req_tag;
                        r_write <= mem_write;
                        r_state <= StCheck;
                    end
                end
                StCheck: begin
                    if (w_hit) begin
                        r_plru[r_set] <= w_plru_next;
                        if (r_write) r_dirty[r_set][w_hit_way] <= 1'b1;
                        r_state <= StIdle;
                    end else if (w_victim_dirty) begin
                        r_victim       <= w_victim;
                        r_pmem_write   <= 1'b1;
                        r_pmem_address <= {r_tag_arr[r_set][w_victim], r_set,
                                           {s_offset{1'b0}}};
                        r_pmem_wdata   <= r_data[r_set][w_victim];
                        r_state        <= StWriteback;
                    end else begin
                        r_victim       <= w_victim;
                        r_pmem_read    <= 1'b1;
                        r_pmem_address <= {r_tag, r_set, {s_offset{1'b0}}};
                        r_state        <= StFill;
                    end
                end
                StWriteback: begin
                    if (pmem_resp) begin
                        r_pmem_write   <= 1'b0;
                        r_pmem_wdata   <= '0;
                        r_pmem_read    <= 1'b1;
                        r_pmem_address <= {r_tag, r_set, {s_offset{1'b0}}};
                        r_state        <= StFill;
                    end
                end
                StFill: begin
                    if (pmem_resp) begin
                        r_pmem_read               <= 1'b0;
                        r_pmem_address            <= '0;
                        r_valid[r_set][r_victim]  <= 1'b1;
                        r_dirty[r_set][r_victim]  <= 1'b0;
                        r_state                   <= StCheck;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Line and tag storage carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (r_state == StCheck && w_hit && r_write) begin
            r_data[r_set][w_hit_way] <= w_merged;
        end
        if (r_state == StFill && pmem_resp) begin
            r_data[r_set][r_victim]    <= pmem_rdata;
            r_tag_arr[r_set][r_victim] <= r_tag;
        end
    end

endmodule

// File: tb/tb_cache_nway.sv
// Randomised and directed bench for cache_nway; a transaction-level cache/memory model
// predicts every output cycle by cycle.
module tb_cache_nway;

    localparam int NS = 8;
    localparam int NW = 4;
    localparam int LG = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [255:0] mem_wdata = '0;
    logic [31:0]  mem_byte_enable256 = '0;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    cache_nway #(
        .s_offset(5),
        .s_index (3),
        .num_ways(4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_address       (mem_address),
        .mem_wdata         (mem_wdata),
        .mem_byte_enable256(mem_byte_enable256),
        .mem_rdata         (mem_rdata),
        .mem_resp          (mem_resp),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_rdata        (pmem_rdata),
        .pmem_resp         (pmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: cache contents, tree pointers and backing memory.
    bit           m_valid [NS][NW];
    bit           m_dirty [NS][NW];
    logic [23:0]  m_tag   [NS][NW];
    logic [255:0] m_data  [NS][NW];
    bit           m_plru  [NS][NW-1];
    logic [255:0] mem_q [logic [31:0]];

    // Expected outputs for the current cycle.
    logic         e_resp = 1'b0, e_pr = 1'b0, e_pw = 1'b0;
    logic [31:0]  e_addr = '0;
    logic [255:0] e_rdata = '0, e_wdata = '0;
    bit           chk_en = 1'b0;

    int           pr_cycles = 0;
    logic [31:0]  last_fill_addr = '0, last_wb_addr = '0;
    logic [255:0] last_wb_data = '0, last_rdata = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_resp", {255'b0, mem_resp}, {255'b0, e_resp});
            chk("mem_rdata", mem_rdata, e_rdata);
            chk("pmem_read", {255'b0, pmem_read}, {255'b0, e_pr});
            chk("pmem_write", {255'b0, pmem_write}, {255'b0, e_pw});
            chk("pmem_address", {224'b0, pmem_address}, {224'b0, e_addr});
            chk("pmem_wdata", pmem_wdata, e_wdata);
        end
        if (pmem_read) begin
            pr_cycles++;
            last_fill_addr = pmem_address;
        end
        if (pmem_write) begin
            last_wb_addr = pmem_address;
            last_wb_data = pmem_wdata;
        end
        if (mem_resp) last_rdata = mem_rdata;
    end

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // Untouched memory holds each word's own byte address.
    function automatic logic [255:0] mem_get(input logic [31:0] a);
        logic [31:0]  base;
        logic [255:0] l;
        base = {a[31:5], 5'b0};
        if (mem_q.exists(base)) return mem_q[base];
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(4 * i);
        return l;
    endfunction

    function automatic int plru_victim(input int s);
        int node, way, d;
        node = 0;
        way  = 0;
        for (int l = 0; l < LG; l++) begin
            d    = int'(m_plru[s][node]);
            way  = way * 2 + d;
            node = 2 * node + 1 + d;
        end
        return way;
    endfunction

    task automatic touch(input int s, input int w);
        int node, d;
        node = 0;
        for (int l = 0; l < LG; l++) begin
            d = (w >> (LG - 1 - l)) & 1;
            m_plru[s][node] = (d == 0);
            node = 2 * node + 1 + d;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
            for (int n = 0; n < NW - 1; n++) m_plru[s][n] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_resp  = 1'b0;
        e_pr    = 1'b0;
        e_pw    = 1'b0;
        e_addr  = '0;
        e_rdata = '0;
        e_wdata = '0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            if ($urandom_range(0, 3) == 0) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rand256();
            end
            step();
            pmem_resp = 1'b0;
        end
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [255:0] wd,
                          input logic [31:0] be, input int wb_dly, input int fill_dly,
                          output bit hit, output bit wb);
        int           s, w;
        logic [23:0]  t;
        logic [255:0] line;
        s   = int'(addr[7:5]);
        t   = addr[31:8];
        hit = 1'b0;
        wb  = 1'b0;
        w   = 0;
        for (int i = 0; i < NW; i++) begin
            if (m_valid[s][i] && m_tag[s][i] == t) begin
                hit = 1'b1;
                w   = i;
            end
        end
        mem_read           = !wr || ($urandom_range(0, 1) == 1);
        mem_write          = wr;
        mem_address        = addr;
        mem_wdata          = wd;
        mem_byte_enable256 = be;
        idle_exp();
        step();
        if (!hit) begin
            w = -1;
            for (int i = NW - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
            if (w < 0) w = plru_victim(s);
            step();
            if (m_valid[s][w] && m_dirty[s][w]) begin
                wb      = 1'b1;
                e_pw    = 1'b1;
                e_addr  = {m_tag[s][w], 3'(s), 5'b0};
                e_wdata = m_data[s][w];
                repeat (wb_dly) step();
                pmem_resp = 1'b1;
                step();
                pmem_resp = 1'b0;
                mem_q[e_addr] = m_data[s][w];
                e_pw    = 1'b0;
                e_wdata = '0;
            end
            e_pr   = 1'b1;
            e_addr = {t, 3'(s), 5'b0};
            repeat (fill_dly) step();
            line       = mem_get(addr);
            pmem_rdata = line;
            pmem_resp  = 1'b1;
            step();
            pmem_resp  = 1'b0;
            pmem_rdata = rand256();
            e_pr   = 1'b0;
            e_addr = '0;
            m_valid[s][w] = 1'b1;
            m_dirty[s][w] = 1'b0;
            m_tag[s][w]   = t;
            m_data[s][w]  = line;
        end
        e_resp  = 1'b1;
        e_rdata = m_data[s][w];
        if (wr) begin
            for (int b = 0; b < 32; b++) if (be[b]) m_data[s][w][8*b +: 8] = wd[8*b +: 8];
            m_dirty[s][w] = 1'b1;
        end
        touch(s, w);
        step();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        idle_exp();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1);
    end

    bit           h, wbf;
    int           pr0;
    logic [255:0] wd;
    logic [31:0]  a;

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_resp", {255'b0, mem_resp}, 256'd0);
        chk("reset_pmem_address", {224'b0, pmem_address}, 256'd0);
        step();
        rst_n = 1'b1;
        step();

        // Cold read then re-read of 0x100.
        pr0 = pr_cycles;
        do_req(1'b0, 32'h0000_0100, '0, '0, 0, 2, h, wbf);
        chk("t1_first_miss", {255'b0, h}, 256'd0);
        chk("t1_fill_addr", {224'b0, last_fill_addr}, 256'h100);
        chk("t1_rdata_w0", {224'b0, last_rdata[31:0]}, 256'h100);
        chk("t1_rdata_w7", {224'b0, last_rdata[255:224]}, 256'h11C);
        gap(1);
        pr0 = pr_cycles;
        do_req(1'b0, 32'h0000_0100, '0, '0, 0, 0, h, wbf);
        chk("t1_rehit", {255'b0, h}, 256'd1);
        chk("t1_rehit_no_fill", pr_cycles - pr0, 256'd0);

        // Partial write then read back.
        wd = rand256();
        wd[31:0] = 32'hDEAD_BEEF;
        do_req(1'b1, 32'h0000_0100, wd, 32'h0000_000F, 0, 0, h, wbf);
        do_req(1'b0, 32'h0000_0100, '0, '0, 0, 0, h, wbf);
        chk("t2_word0", {224'b0, last_rdata[31:0]}, 256'hDEAD_BEEF);
        chk("t2_word1", {224'b0, last_rdata[63:32]}, 256'h104);
        chk("t2_word7", {224'b0, last_rdata[255:224]}, 256'h11C);

        // Set 2: fill tags 1..4, touch tag 1, miss on tag 5.
        for (int i = 1; i <= 4; i++) do_req(1'b0, 32'(i * 256 + 'h40), '0, '0, 0, 1, h, wbf);
        do_req(1'b0, 32'h0000_0140, '0, '0, 0, 0, h, wbf);
        do_req(1'b0, 32'h0000_0540, '0, '0, 0, 1, h, wbf);
        chk("t3_clean_no_wb", {255'b0, wbf}, 256'd0);
        chk("t3_fill_addr", {224'b0, last_fill_addr}, 256'h540);
        pr0 = pr_cycles;
        do_req(1'b0, 32'h0000_0240, '0, '0, 0, 0, h, wbf);
        chk("t3_tag2_kept", pr_cycles - pr0, 256'd0);
        do_req(1'b0, 32'h0000_0340, '0, '0, 0, 0, h, wbf);
        chk("t3_tag3_evicted", {255'b0, h}, 256'd0);

        // Set 5: dirty tag 1 becomes the PLRU victim.
        do_req(1'b1, 32'h0000_01A0, {8{32'h1234_5678}}, '1, 0, 0, h, wbf);
        for (int i = 2; i <= 4; i++) do_req(1'b0, 32'(i * 256 + 'hA0), '0, '0, 0, 0, h, wbf);
        do_req(1'b0, 32'h0000_06A0, '0, '0, 2, 1, h, wbf);
        chk("t4_wb_happened", {255'b0, wbf}, 256'd1);
        chk("t4_wb_addr", {224'b0, last_wb_addr}, 256'h1A0);
        chk("t4_wb_data", {224'b0, last_wb_data[31:0]}, 256'h1234_5678);
        chk("t4_fill_addr", {224'b0, last_fill_addr}, 256'h6A0);

        // Long fill stall.
        pr0 = pr_cycles;
        do_req(1'b0, 32'h7000_0080, '0, '0, 0, 20, h, wbf);
        chk("t5_fill_cycles", pr_cycles - pr0, 256'd21);
        chk("t5_rdata", {224'b0, last_rdata[31:0]}, 256'h7000_0080);

        // Reset while writing back a dirty victim in set 7.
        do_req(1'b1, 32'h0000_01E0, rand256(), '1, 0, 0, h, wbf);
        for (int i = 2; i <= 4; i++) do_req(1'b0, 32'(i * 256 + 'hE0), '0, '0, 0, 0, h, wbf);
        mem_read    = 1'b1;
        mem_address = 32'h0000_05E0;
        idle_exp();
        step();
        step();
        e_pw    = 1'b1;
        e_addr  = 32'h0000_01E0;
        e_wdata = m_data[7][0];
        @(negedge clk);
        chk("t6_in_writeback", {255'b0, pmem_write}, 256'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle_exp();
        #1;
        chk("t6_write_drop", {255'b0, pmem_write}, 256'd0);
        chk("t6_read_low", {255'b0, pmem_read}, 256'd0);
        mem_read = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        step();
        pr0 = pr_cycles;
        do_req(1'b0, 32'h0000_01E0, '0, '0, 0, 0, h, wbf);
        chk("t6_miss_after_reset", pr_cycles - pr0, 256'd1);
        do_req(1'b0, 32'h0000_0100, '0, '0, 0, 0, h, wbf);
        chk("t6_set0_miss", {255'b0, h}, 256'd0);

        // Random traffic over a small tag pool to force conflicts and write-backs.
        for (int n = 0; n < 300; n++) begin
            a = {16'h0, 8'($urandom_range(1, 6)), 3'($urandom_range(0, 7)), 5'($urandom())};
            do_req($urandom_range(0, 1) == 1, a, rand256(),
                   (n % 10 == 0) ? 32'h0 : $urandom(),
                   $urandom_range(0, 3), $urandom_range(0, 3), h, wbf);
            gap($urandom_range(0, 2));
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
